// File: rtl/encoder_generator.sv
`default_nettype none
// encoder_generator: emits N full A/B quadrature cycles, Q clocks per quarter, in either direction.
// Revision 1.0
module encoder_generator #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic             CMD_DIR,
  input  logic [CNT_W-1:0] CMD_COUNT,
  input  logic [CNT_W-1:0] CMD_QUARTER,
  input  logic             ABORT,
  output logic             SIG_A,
  output logic             SIG_B,
  output logic [CNT_W-1:0] REMAIN,
  output logic             DONE
);

  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_RUN  = 1'b1;
  localparam logic [CNT_W-1:0] ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic             dir;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] qcnt;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] q_init;
  logic [1:0]       sub;
  logic [1:0]       phase;
  logic [1:0]       phase_next;
  logic             done;
  logic             accept;
  logic             active;
  logic             tick;
  logic             last;
  logic             finish;

  assign accept = (state == S_IDLE) && CMD_VALID;
  // A running command advances only when not aborted and cycles remain.
  assign active = (state == S_RUN) && !ABORT && (remain != '0);
  assign tick   = active && (qcnt == '0);
  assign last   = tick && (sub == 2'd3) && (remain == ONE);
  assign finish = (state == S_RUN) && !ABORT && ((remain == '0) || last);

  // Counter holds Q-1 so that the transition lands exactly Q edges later; Q=0 behaves as Q=1.
  assign q_init = (CMD_QUARTER == '0) ? '0 : (CMD_QUARTER - ONE);

  assign phase_next = dir ? {phase[0], ~phase[1]} : {~phase[0], phase[1]};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (CMD_VALID) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (ABORT || finish) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state == S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dir    <= 1'b0;
      reload <= '0;
      qcnt   <= '0;
      remain <= '0;
      sub    <= 2'd0;
      phase  <= 2'b00;
      done   <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        dir    <= CMD_DIR;
        reload <= q_init;
        qcnt   <= q_init;
        remain <= CMD_COUNT;
        sub    <= 2'd0;
      end else if (active) begin
        if (tick) begin
          qcnt  <= reload;
          phase <= phase_next;
          sub   <= sub + 2'd1;
          if (sub == 2'd3) begin
            remain <= remain - ONE;
          end
        end else begin
          qcnt <= qcnt - ONE;
        end
      end
    end
  end

  assign SIG_A  = phase[1];
  assign SIG_B  = phase[0];
  assign REMAIN = remain;
  assign DONE   = done;

endmodule
`default_nettype wire

// File: tb/tb_encoder_generator.sv
`default_nettype none
// Testbench for encoder_generator: directed scenarios plus random commands vs. a cycle-level model.
module tb_encoder_generator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_dir = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cmd_count = '0;
  logic [W-1:0] cmd_quarter = '0;
  logic         cmd_ready;
  logic         sig_a;
  logic         sig_b;
  logic         done;
  logic [W-1:0] remain;

  always #5 clk = ~clk;

  encoder_generator #(.CNT_W(W)) dut (
    .CLK        (clk),
    .RST        (rst_n),
    .CMD_VALID  (cmd_valid),
    .CMD_READY  (cmd_ready),
    .CMD_DIR    (cmd_dir),
    .CMD_COUNT  (cmd_count),
    .CMD_QUARTER(cmd_quarter),
    .ABORT      (abort),
    .SIG_A      (sig_a),
    .SIG_B      (sig_b),
    .REMAIN     (remain),
    .DONE       (done)
  );

  typedef struct packed {
    logic [1:0]   ab;
    logic [W-1:0] rem;
    logic         dn;
    logic         rdy;
  } snap_t;

  snap_t exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: position within the clockwise cycle 00,10,11,01.
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_dir  = 1'b0;
  int m_k = 0;
  int m_n = 0;
  int m_q = 1;
  int m_start = 0;
  int m_pos = 0;
  int m_rem = 0;

  function automatic snap_t model_snap();
    snap_t s;
    s.ab  = seq[m_pos];
    s.rem = W'(m_rem);
    s.dn  = m_done;
    s.rdy = ~m_busy;
    return s;
  endfunction

  task automatic model_edge(input bit v, input bit d, input int n, input int q, input bit ab);
    int tr;
    m_done = 1'b0;
    if (!m_busy) begin
      if (v) begin
        m_busy  = 1'b1;
        m_k     = 0;
        m_n     = n;
        m_q     = (q == 0) ? 1 : q;
        m_dir   = d;
        m_start = m_pos;
        m_rem   = n;
      end
    end else begin
      m_k = m_k + 1;
      if (ab) begin
        m_busy = 1'b0;
      end else if (m_n == 0) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end else begin
        tr    = m_k / m_q;
        m_pos = (m_start + (m_dir ? 4 - (tr % 4) : (tr % 4))) % 4;
        m_rem = m_n - tr / 4;
        if (tr == 4 * m_n) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic check(input string name, input snap_t got, input snap_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got ab=%b rem=%0d done=%b rdy=%b, expected ab=%b rem=%0d done=%b rdy=%b",
               name, cyc, got.ab, got.rem, got.dn, got.rdy, exp.ab, exp.rem, exp.dn, exp.rdy);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  initial begin
    forever begin
      snap_t e;
      snap_t g;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {sig_a, sig_b, remain, done, cmd_ready};
        check("snapshot", g, e);
      end
    end
  end

  task automatic step(input bit v, input bit d, input int n, input int q, input bit ab);
    cmd_valid   = v;
    cmd_dir     = d;
    cmd_count   = W'(n);
    cmd_quarter = W'(q);
    abort       = ab;
    @(posedge clk);
    model_edge(v, d, n, q, ab);
    exp_q.push_back(model_snap());
    #2;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Asserts reset between the falling edge and the next rising edge, checks it took effect asynchronously.
  task automatic do_reset_mid();
    snap_t rs;
    #6;
    rst_n = 1'b0;
    #1;
    rs = {2'b00, {W{1'b0}}, 1'b0, 1'b1};
    check("async_reset", {sig_a, sig_b, remain, done, cmd_ready}, rs);
    m_busy = 1'b0;
    m_done = 1'b0;
    m_pos  = 0;
    m_rem  = 0;
    @(posedge clk);
    #2;
    check("reset_hold", {sig_a, sig_b, remain, done, cmd_ready}, rs);
    rst_n = 1'b1;
  endtask

  initial begin
    snap_t rs;
    int    guard;
    rs = {2'b00, {W{1'b0}}, 1'b0, 1'b1};
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2;
    check("reset_init", {sig_a, sig_b, remain, done, cmd_ready}, rs);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Clockwise, 2 cycles, quarter 3.
    step(1'b1, 1'b0, 2, 3, 1'b0);
    idle(26);
    // Counterclockwise, 1 cycle, quarter 0 treated as 1.
    step(1'b1, 1'b1, 1, 0, 1'b0);
    idle(5);
    // Zero-count command; abort at acceptance ignored.
    step(1'b1, 1'b0, 0, 5, 1'b1);
    idle(3);
    // Abort mid-run, then continue from the held phase.
    step(1'b1, 1'b0, 3, 2, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b1, 1'b0, 1, 1, 1'b0);
    idle(5);
    // Reset while running with phase 11.
    step(1'b1, 1'b0, 2, 2, 1'b0);
    idle(8);
    do_reset_mid();
    // Commands during RUN ignored; back-to-back acceptance in the DONE cycle.
    step(1'b1, 1'b0, 1, 1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 7, 3, 1'b0);
    step(1'b1, 1'b1, 2, 1, 1'b0);
    idle(10);
    // Longest quarter period at this counter width.
    step(1'b1, 1'b1, 1, 15, 1'b0);
    idle(62);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 3) == 0, $urandom % 2, $urandom % 4,
           (($urandom % 8) == 0) ? 15 : ($urandom % 4), ($urandom % 50) == 0);
      if (($urandom % 400) == 0) do_reset_mid();
    end

    guard = 0;
    while (m_busy && guard < 1000) begin
      idle(1);
      guard++;
    end
    idle(2);
    #10;
    tests++;
    if (exp_q.size() != 0 || m_busy) begin
      fails++;
      $display("FAIL drain: %0d expectations left, model busy=%0d, expected 0 and 0", exp_q.size(), m_busy);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
